rotor_stepper: RTL and testbench

- Stepping controller that sits directly upstream of the three rotor instances.
- Turns a key-press request into correctly timed rotate pulses for the right, middle and left rotors, using Enigma notch and turnover rules.
- Keeps a shadow copy of each rotor's position, supports zeroing the rotors and seeking them to a programmed start position.
- Tells the downstream path when the rotor chain has settled and the scrambled letter may be sampled.

---
 rtl/rotor_stepper_if.sv | 31 +++
 rtl/rotor_stepper.sv | 259 +++++++++++++++++++++++++
 tb/tb_rotor_stepper.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rotor_stepper_if.sv
// rotor_stepper_if: request/handshake and rotor-drive bundle for rotor_stepper.
// master = requester side (key/seek/zero requests), slave = rotor_stepper.
interface rotor_stepper_if;
    logic        key_valid;
    logic        key_ready;
    logic        set_valid;
    logic [14:0] set_pos;
    logic        zero_req;
    logic        set_err;
    logic        rotate_r;
    logic        rotate_m;
    logic        rotate_l;
    logic        rotor_reset;
    logic [4:0]  pos_r;
    logic [4:0]  pos_m;
    logic [4:0]  pos_l;
    logic        enc_valid;
    logic        busy;

    modport master (
        output key_valid, set_valid, set_pos, zero_req,
        input  key_ready, set_err, rotate_r, rotate_m, rotate_l, rotor_reset,
               pos_r, pos_m, pos_l, enc_valid, busy
    );

    modport slave (
        input  key_valid, set_valid, set_pos, zero_req,
        output key_ready, set_err, rotate_r, rotate_m, rotate_l, rotor_reset,
               pos_r, pos_m, pos_l, enc_valid, busy
    );
endinterface

// File: rtl/rotor_stepper.sv
// rotor_stepper: turns key presses into Enigma-style rotate strobes for the
// right/middle/left rotors, keeps shadow positions, and supports zeroing and
// seeking to a programmed start position.
// Build option: define DOUBLE_STEP_EN for the historical middle-rotor
// double-step; leave undefined for pure odometer stepping.
module rotor_stepper #(
    parameter int unsigned NOTCH_R       = 16,
    parameter int unsigned NOTCH_M       = 4,
    parameter int unsigned NOTCH_L       = 21,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic            clock,
    input  logic            reset,
    rotor_stepper_if.slave  bus
);

    // Parameter sanity checks at elaboration time.
    if (NOTCH_R > 25 || NOTCH_M > 25 || NOTCH_L > 25) begin : g_bad_notch
        $error("rotor_stepper: notch positions must be 0..25");
    end
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("rotor_stepper: SETTLE_CYCLES must be 1..15");
    end

    localparam logic [4:0] NR       = 5'(NOTCH_R);
    localparam logic [4:0] NM       = 5'(NOTCH_M);
    localparam logic [4:0] LAST_POS = 5'd25;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_STEP,
        ST_SETTLE,
        ST_VALID,
        ST_SEEK_PULSE,
        ST_SEEK_GAP,
        ST_SEEK_ERR,
        ST_ZPREP,
        ST_ZPULSE,
        ST_ZGAP
    } state_t;

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic [4:0] pos_r, pos_m, pos_l;
    logic [4:0] pos_r_nx, pos_m_nx, pos_l_nx;
    logic [4:0] tgt_r, tgt_m, tgt_l;
    logic [4:0] tgt_r_nx, tgt_m_nx, tgt_l_nx;
    logic       rot_r, rot_m, rot_l;
    logic       rot_r_nx, rot_m_nx, rot_l_nx;
    logic       rrst, rrst_nx;
    logic       enc, enc_nx;
    logic       err, err_nx;
    logic       ready, ready_nx;
    logic       busy_q, busy_nx;

    logic [4:0] req_l, req_m, req_r;
    logic       req_bad;
    logic [4:0] seek_l, seek_m, seek_r;
    logic       need_l, need_m, need_r;
    logic       key_m, key_l;

    function automatic logic [4:0] inc_pos(input logic [4:0] p);
        return (p == LAST_POS) ? 5'd0 : p + 5'd1;
    endfunction

    assign req_l   = bus.set_pos[14:10];
    assign req_m   = bus.set_pos[9:5];
    assign req_r   = bus.set_pos[4:0];
    assign req_bad = (req_l > LAST_POS) || (req_m > LAST_POS) || (req_r > LAST_POS);

    // Seek targets come straight from set_pos on acceptance, from the latched copy afterwards.
    always_comb begin
        seek_l = tgt_l;
        seek_m = tgt_m;
        seek_r = tgt_r;
        if (state == ST_IDLE) begin
            seek_l = req_l;
            seek_m = req_m;
            seek_r = req_r;
        end
        need_l = (pos_l != seek_l);
        need_m = (pos_m != seek_m);
        need_r = (pos_r != seek_r);
    end

    // Notch decisions for a key step, based on positions before the step.
`ifdef DOUBLE_STEP_EN
    always_comb begin
        key_l = (pos_m == NM);
        key_m = (pos_r == NR) || key_l;
    end
`else
    // Odometer: the left rotor only advances when the middle rotor actually
    // turns over, so the middle notch alone never moves it.
    always_comb begin
        key_m = (pos_r == NR);
        key_l = key_m && (pos_m == NM);
    end
`endif

    // Next-state and next-output logic; every output is registered from here.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pos_r_nx = pos_r;
        pos_m_nx = pos_m;
        pos_l_nx = pos_l;
        tgt_r_nx = tgt_r;
        tgt_m_nx = tgt_m;
        tgt_l_nx = tgt_l;
        rot_r_nx = 1'b0;
        rot_m_nx = 1'b0;
        rot_l_nx = 1'b0;
        rrst_nx  = 1'b0;
        enc_nx   = 1'b0;
        err_nx   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (bus.zero_req) begin
                    state_nx = ST_ZPREP;
                    rrst_nx  = 1'b1;
                end else if (bus.set_valid) begin
                    if (req_bad) begin
                        state_nx = ST_SEEK_ERR;
                        err_nx   = 1'b1;
                    end else begin
                        tgt_l_nx = req_l;
                        tgt_m_nx = req_m;
                        tgt_r_nx = req_r;
                        rot_l_nx = need_l;
                        rot_m_nx = need_m;
                        rot_r_nx = need_r;
                        if (need_l) pos_l_nx = inc_pos(pos_l);
                        if (need_m) pos_m_nx = inc_pos(pos_m);
                        if (need_r) pos_r_nx = inc_pos(pos_r);
                        // Already on target: spend the single GAP cycle, then back to IDLE.
                        state_nx = (need_l || need_m || need_r) ? ST_SEEK_PULSE : ST_SEEK_GAP;
                    end
                end else if (bus.key_valid) begin
                    state_nx = ST_STEP;
                    rot_r_nx = 1'b1;
                    rot_m_nx = key_m;
                    rot_l_nx = key_l;
                    pos_r_nx = inc_pos(pos_r);
                    if (key_m) pos_m_nx = inc_pos(pos_m);
                    if (key_l) pos_l_nx = inc_pos(pos_l);
                end
            end

            ST_STEP: begin
                state_nx = ST_SETTLE;
                cnt_nx   = SETTLE_LOAD;
            end

            ST_SETTLE: begin
                if (cnt == 4'd0) begin
                    state_nx = ST_VALID;
                    enc_nx   = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end

            ST_VALID: state_nx = ST_IDLE;

            ST_SEEK_PULSE: state_nx = ST_SEEK_GAP;

            ST_SEEK_GAP: begin
                if (need_l || need_m || need_r) begin
                    state_nx = ST_SEEK_PULSE;
                    rot_l_nx = need_l;
                    rot_m_nx = need_m;
                    rot_r_nx = need_r;
                    if (need_l) pos_l_nx = inc_pos(pos_l);
                    if (need_m) pos_m_nx = inc_pos(pos_m);
                    if (need_r) pos_r_nx = inc_pos(pos_r);
                end else begin
                    state_nx = ST_IDLE;
                end
            end

            ST_SEEK_ERR: state_nx = ST_IDLE;

            ST_ZPREP: begin
                state_nx = ST_ZPULSE;
                rrst_nx  = 1'b1;
                rot_r_nx = 1'b1;
                rot_m_nx = 1'b1;
                rot_l_nx = 1'b1;
                pos_r_nx = '0;
                pos_m_nx = '0;
                pos_l_nx = '0;
            end

            ST_ZPULSE: state_nx = ST_ZGAP;

            ST_ZGAP: state_nx = ST_IDLE;

            default: state_nx = ST_IDLE;
        endcase

        ready_nx = (state_nx == ST_IDLE);
        busy_nx  = (state_nx != ST_IDLE);
    end

    // State, shadow positions and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            pos_r  <= '0;
            pos_m  <= '0;
            pos_l  <= '0;
            tgt_r  <= '0;
            tgt_m  <= '0;
            tgt_l  <= '0;
            rot_r  <= 1'b0;
            rot_m  <= 1'b0;
            rot_l  <= 1'b0;
            rrst   <= 1'b0;
            enc    <= 1'b0;
            err    <= 1'b0;
            ready  <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            pos_r  <= pos_r_nx;
            pos_m  <= pos_m_nx;
            pos_l  <= pos_l_nx;
            tgt_r  <= tgt_r_nx;
            tgt_m  <= tgt_m_nx;
            tgt_l  <= tgt_l_nx;
            rot_r  <= rot_r_nx;
            rot_m  <= rot_m_nx;
            rot_l  <= rot_l_nx;
            rrst   <= rrst_nx;
            enc    <= enc_nx;
            err    <= err_nx;
            ready  <= ready_nx;
            busy_q <= busy_nx;
        end
    end

    assign bus.key_ready   = ready;
    assign bus.busy        = busy_q;
    assign bus.set_err     = err;
    assign bus.enc_valid   = enc;
    assign bus.rotate_r    = rot_r;
    assign bus.rotate_m    = rot_m;
    assign bus.rotate_l    = rot_l;
    assign bus.rotor_reset = rrst;
    assign bus.pos_r       = pos_r;
    assign bus.pos_m       = pos_m;
    assign bus.pos_l       = pos_l;

endmodule

// File: tb/tb_rotor_stepper.sv
// tb_rotor_stepper: scoreboard bench for rotor_stepper. Stimulus pushes the
// expected rotor events; a negedge monitor pops and compares every event.
module tb_rotor_stepper;

    logic clock = 1'b0;
    logic reset = 1'b0;

    rotor_stepper_if bus ();

    rotor_stepper #(
        .NOTCH_R(16),
        .NOTCH_M(4),
        .NOTCH_L(21),
        .SETTLE_CYCLES(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Event word: {rot_l, rot_m, rot_r, rotor_reset, enc_valid, set_err, pos_l, pos_m, pos_r}
    logic [20:0] exp_q[$];

    // Bench-side expected shadow positions.
    logic [4:0] el, em, er;

    function automatic logic [20:0] ev(input logic l, input logic m, input logic r,
                                       input logic rr, input logic enc, input logic err,
                                       input logic [4:0] pl, input logic [4:0] pm,
                                       input logic [4:0] pr);
        return {l, m, r, rr, enc, err, pl, pm, pr};
    endfunction

    function automatic logic [4:0] wrap_inc(input logic [4:0] p);
        return (p == 5'd25) ? 5'd0 : p + 5'd1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: any strobe, enc_valid or set_err is an event that must match the queue head.
    always @(negedge clock) begin
        logic [20:0] act;
        act = {bus.rotate_l, bus.rotate_m, bus.rotate_r, bus.rotor_reset, bus.enc_valid,
               bus.set_err, bus.pos_l, bus.pos_m, bus.pos_r};
        if (reset && (bus.rotate_r || bus.rotate_m || bus.rotate_l || bus.enc_valid || bus.set_err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got %0h expected no event", act);
            end else begin
                check("event", 32'(act), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!bus.key_ready && n < 200) begin
            tick();
            n++;
        end
        check({name, "_idle_timeout"}, 32'(n < 200), 32'd1);
    endtask

    task automatic check_pos(input string name, input logic [4:0] l, input logic [4:0] m,
                             input logic [4:0] r);
        check(name, {17'd0, bus.pos_l, bus.pos_m, bus.pos_r}, {17'd0, l, m, r});
    endtask

    // One key press with hand-computed strobes and resulting positions.
    task automatic press(input string name, input logic sl, input logic sm,
                         input logic [4:0] pl, input logic [4:0] pm, input logic [4:0] pr);
        int n;
        exp_q.push_back(ev(sl, sm, 1'b1, 1'b0, 1'b0, 1'b0, pl, pm, pr));
        exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, pl, pm, pr));
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        n = 1;
        while (!bus.enc_valid && n < 20) begin
            tick();
            n++;
        end
        check({name, "_enc_latency"}, 32'(n), 32'd4);
        wait_idle(name);
        check_pos({name, "_pos"}, pl, pm, pr);
        el = pl; em = pm; er = pr;
    endtask

    // Seek to a valid target; the expected pulse train comes from the stepping rule.
    task automatic seek(input string name, input logic [4:0] tl, input logic [4:0] tm,
                        input logic [4:0] tr);
        int pulses;
        int b;
        logic sl, sm, sr;
        pulses = 0;
        while ((el != tl || em != tm || er != tr) && pulses < 30) begin
            sl = (el != tl);
            sm = (em != tm);
            sr = (er != tr);
            if (sl) el = wrap_inc(el);
            if (sm) em = wrap_inc(em);
            if (sr) er = wrap_inc(er);
            exp_q.push_back(ev(sl, sm, sr, 1'b0, 1'b0, 1'b0, el, em, er));
            pulses++;
        end
        bus.set_pos   = {tl, tm, tr};
        bus.set_valid = 1'b1;
        tick();
        bus.set_valid = 1'b0;
        b = 0;
        while (bus.busy && b < 100) begin
            b++;
            tick();
        end
        check({name, "_busy_cycles"}, 32'(b), (pulses == 0) ? 32'd1 : 32'(2 * pulses));
        check_pos({name, "_pos"}, tl, tm, tr);
    endtask

    // Zero sequence, optionally with competing requests in the same cycle.
    task automatic zero(input string name, input logic with_others);
        int rr_cnt;
        int busy_cnt;
        exp_q.push_back(ev(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0));
        bus.zero_req  = 1'b1;
        bus.set_valid = with_others;
        bus.key_valid = with_others;
        bus.set_pos   = {5'd1, 5'd2, 5'd3};
        tick();
        bus.zero_req  = 1'b0;
        bus.set_valid = 1'b0;
        bus.key_valid = 1'b0;
        rr_cnt   = 0;
        busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.rotor_reset) rr_cnt++;
            if (bus.busy) busy_cnt++;
            tick();
        end
        check({name, "_rotor_reset_cycles"}, 32'(rr_cnt), 32'd2);
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'd3);
        check_pos({name, "_pos"}, 5'd0, 5'd0, 5'd0);
        el = '0; em = '0; er = '0;
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_strobes"},
              {26'd0, bus.rotate_l, bus.rotate_m, bus.rotate_r, bus.rotor_reset,
               bus.enc_valid, bus.set_err}, 32'd0);
        check({name, "_ready_busy"}, {30'd0, bus.key_ready, bus.busy}, 32'd2);
        check_pos({name, "_pos"}, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        int acc;
        int n;
        bus.key_valid = 1'b0;
        bus.set_valid = 1'b0;
        bus.zero_req  = 1'b0;
        bus.set_pos   = '0;
        el = '0; em = '0; er = '0;

        // Power-on reset held for 3 cycles.
        repeat (3) @(posedge clock);
        #1;
        check_reset_state("por");
        @(negedge clock);
        reset = 1'b1;
        tick();
        check_pos("pre_press_pos", 5'd0, 5'd0, 5'd0);

        press("press0", 1'b0, 1'b0, 5'd0, 5'd0, 5'd1);

        // Seek to (0,3,16) then two presses across the notches.
        seek("seek1", 5'd0, 5'd3, 5'd16);
        press("press1", 1'b0, 1'b1, 5'd0, 5'd4, 5'd17);
`ifdef DOUBLE_STEP_EN
        press("press2", 1'b1, 1'b1, 5'd1, 5'd5, 5'd18);
`else
        press("press2", 1'b0, 1'b0, 5'd0, 5'd4, 5'd18);
`endif

        // Out-of-range middle field: set_err only, ready again next cycle.
        exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, el, em, er));
        bus.set_pos   = {5'd5, 5'd26, 5'd0};
        bus.set_valid = 1'b1;
        tick();
        bus.set_valid = 1'b0;
        check("seek_err_pulse", {30'd0, bus.set_err, bus.key_ready}, 32'd2);
        tick();
        check("seek_err_ready", {30'd0, bus.set_err, bus.key_ready}, 32'd1);
        check_pos("seek_err_pos", el, em, er);

        // Seek onto the current position: one busy cycle, no strobes.
        seek("seek_same", el, em, er);

        seek("seek2", 5'd3, 5'd7, 5'd25);
        zero("zero", 1'b0);

        // key_valid held high: exactly one step per completed sequence.
        exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd1));
        exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd1));
        exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd2));
        exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd2));
        bus.key_valid = 1'b1;
        acc = 0;
        n = 0;
        while (acc < 2 && n < 100) begin
            @(negedge clock);
            if (bus.key_ready) acc++;
            n++;
        end
        check("held_key_accepts", 32'(acc), 32'd2);
        tick();
        bus.key_valid = 1'b0;
        wait_idle("held_key");
        check_pos("held_key_pos", 5'd0, 5'd0, 5'd2);
        el = '0; em = '0; er = 5'd2;

        // All three requests at once: zero wins, nothing else happens.
        zero("zero_all", 1'b1);

        // Async reset in SETTLE: outputs drop without a clock edge; no enc_valid.
        exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd1));
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        tick();
        check("settle_busy", 32'(bus.busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_state("mid_reset");
        repeat (4) tick();
        @(negedge clock);
        reset = 1'b1;
        repeat (6) tick();
        check_reset_state("post_reset");

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
